// File: rtl/fpadd_arbiter_pkg.sv
// Shared types and constants for the floating-point adder arbiter slice.
// The state encoding is fixed so that state values stay stable across tools.
package fpaddarbpkg;

    localparam int NREQ_DEFAULT = 4;
    localparam int IDW          = $clog2(NREQ_DEFAULT);

    typedef enum logic [1:0] {
        A_IDLE    = 2'd0,
        A_LAUNCH  = 2'd1,
        A_WAIT    = 2'd2,
        A_RESPOND = 2'd3
    } ArbStateType;

endpackage

// File: rtl/fpadd_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request bit searching upward
// from the slot after i_last, wrapping around.
module rr_picker #(
    parameter int NREQ = 4,
    parameter int IDXW = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDXW-1:0] i_last,
    output logic            o_found,
    output logic [IDXW-1:0] o_grant
);

    int w_idx;

    // Scan from farthest to nearest so the nearest requester overwrites last.
    always_comb begin
        o_found = 1'b0;
        o_grant = '0;
        w_idx   = 0;
        for (int k = NREQ; k >= 1; k--) begin
            w_idx = (int'(i_last) + k >= NREQ) ? (int'(i_last) + k - NREQ)
                                               : (int'(i_last) + k);
            if (i_req[w_idx[IDXW-1:0]]) begin
                o_found = 1'b1;
                o_grant = w_idx[IDXW-1:0];
            end else begin
                o_found = o_found;
            end
        end
    end

endmodule

// File: rtl/fpadd_arbiter.sv
// Round-robin arbiter/sequencer sharing one floating-point adder among NREQ
// requesters, with a saturating watchdog that turns a hung adder into an error response.
module fpadd_arbiter
    import fpaddarbpkg::*;
#(
    parameter int NREQ         = NREQ_DEFAULT,
    parameter int EXPBITS      = 8,
    parameter int MANTISSABITS = 23,
    parameter int WIDTH        = 1 + EXPBITS + MANTISSABITS,
    parameter int TIMEOUT      = 64
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [NREQ-1:0]       i_ReqValid,
    input  logic [NREQ*WIDTH-1:0] i_ReqA,
    input  logic [NREQ*WIDTH-1:0] i_ReqB,
    output logic [NREQ-1:0]       o_ReqReady,
    output logic [NREQ-1:0]       o_RspValid,
    input  logic [NREQ-1:0]       i_RspReady,
    output logic [WIDTH-1:0]      o_RspData,
    output logic                  o_RspErr,
    output logic                  o_Go,
    output logic [WIDTH-1:0]      o_OpA,
    output logic [WIDTH-1:0]      o_OpB,
    input  logic                  i_AdderDone,
    input  logic [WIDTH-1:0]      i_AdderSum,
    output logic                  o_Busy
);

    localparam int              IDXW     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int              WDW      = $clog2(TIMEOUT + 1);
    localparam logic [IDXW-1:0] LAST_RST = IDXW'(NREQ - 1);
    localparam logic [WDW-1:0]  WD_LIMIT = WDW'(TIMEOUT);

    ArbStateType      r_state;
    logic [IDXW-1:0]  r_grant;
    logic [IDXW-1:0]  r_last;
    logic [WDW-1:0]   r_wdog;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_rsp_data;
    logic             r_rsp_err;

    logic             w_found;
    logic [IDXW-1:0]  w_pick;
    logic             w_accept;
    logic             w_rsp_take;
    logic             w_wd_expire;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;

    rr_picker #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr_picker (
        .i_req   (i_ReqValid),
        .i_last  (r_last),
        .o_found (w_found),
        .o_grant (w_pick)
    );

    assign w_accept    = (r_state == A_IDLE) && w_found;
    assign w_rsp_take  = (r_state == A_RESPOND) && i_RspReady[r_grant];
    // This WAIT cycle is the TIMEOUT-th one when the counter holds TIMEOUT-1.
    assign w_wd_expire = (r_wdog >= (WD_LIMIT - WDW'(1)));

    assign o_ReqReady = w_accept ? (NREQ'(1) << w_pick) : '0;
    assign o_RspValid = (r_state == A_RESPOND) ? (NREQ'(1) << r_grant) : '0;
    assign o_Go       = (r_state == A_LAUNCH);
    assign o_Busy     = (r_state != A_IDLE);
    assign o_OpA      = r_opa;
    assign o_OpB      = r_opb;
    assign o_RspData  = r_rsp_data;
    assign o_RspErr   = r_rsp_err;

    // Operand mux for the picked requester.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_pick == IDXW'(i)) begin
                w_sel_a = i_ReqA[i*WIDTH +: WIDTH];
                w_sel_b = i_ReqB[i*WIDTH +: WIDTH];
            end else begin
                w_sel_a = w_sel_a;
            end
        end
    end

    // Sequencer FSM, operand/result latches and watchdog.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state    <= A_IDLE;
            r_grant    <= '0;
            r_last     <= LAST_RST;
            r_wdog     <= '0;
            r_opa      <= '0;
            r_opb      <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            case (r_state)
                A_IDLE: begin
                    if (w_accept) begin
                        r_grant <= w_pick;
                        r_opa   <= w_sel_a;
                        r_opb   <= w_sel_b;
                        r_state <= A_LAUNCH;
                    end
                end
                A_LAUNCH: begin
                    r_wdog  <= '0;
                    r_state <= A_WAIT;
                end
                A_WAIT: begin
                    r_wdog <= (r_wdog == WD_LIMIT) ? r_wdog : (r_wdog + WDW'(1));
                    if (i_AdderDone) begin
                        r_rsp_data <= i_AdderSum;
                        r_rsp_err  <= 1'b0;
                        r_state    <= A_RESPOND;
                    end else if (w_wd_expire) begin
                        r_rsp_data <= '0;
                        r_rsp_err  <= 1'b1;
                        r_state    <= A_RESPOND;
                    end
                end
                A_RESPOND: begin
                    if (w_rsp_take) begin
                        r_last  <= r_grant;
                        r_state <= A_IDLE;
                    end
                end
                default: begin
                    r_state <= A_IDLE;
                end
            endcase
        end
    end

endmodule
